// File: rtl/modport_ram.sv
// modport_ram: simple dual-port synchronous RAM, read-first, async active-low clear
module modport_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  // read port holds its last value when idle; reads old contents on a same-address write
  always_comb rd_data_d = rd_enb ? mem_q[rd_addr] : rd_data_q;
  // storage array, fully cleared by reset so stale data never survives it
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem_q <= '{default: '0};
    else if (wr_enb) mem_q[wr_addr] <= wr_data;
  // registered read data, one clock of latency
  always_ff @(posedge clk or negedge rst)
    if (!rst) rd_data_q <= '0;
    else rd_data_q <= rd_data_d;
  assign rd_data = rd_data_q;
endmodule

// File: tb/tb_modport_ram.sv
// tb_modport_ram: directed stimulus with a behavioural memory model and per-cycle compare
module tb_modport_ram;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_enb = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_enb = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [7:0] rd_data;
  int         checks = 0;
  int         errors = 0;
  logic       cmp_en = 1'b0;
  logic [7:0] mdl [256];
  logic [7:0] exp_rd = '0;

  modport_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) mdl[i] = '0;

  // reference: reset clears everything; reads see contents before this edge's write
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mdl[i] = '0;
      exp_rd = '0;
    end else begin
      if (rd_enb) exp_rd = mdl[rd_addr];
      if (wr_enb) mdl[wr_addr] = wr_data;
    end
  end

  // continuous comparison away from the active edge
  always @(negedge clk) if (cmp_en) begin
    checks++;
    if (rd_data !== exp_rd) begin
      errors++;
      $display("FAIL model_cmp t=%0t rd_data=%h expected=%h", $time, rd_data, exp_rd);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s rd_data=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                       input logic re, input logic [7:0] ra);
    wr_enb = we; wr_addr = wa; wr_data = wd; rd_enb = re; rd_addr = ra;
  endtask

  initial begin
    #2 rst = 1'b0;
    cmp_en = 1'b1;
    #1 chk("reset_immediate", rd_data, 8'h00);
    tick(); tick();
    chk("reset_hold", rd_data, 8'h00);
    rst = 1'b1;
    drive(0, 8'h00, 8'h00, 1, 8'h00); tick();
    chk("post_reset_rd_00", rd_data, 8'h00);
    drive(0, 8'h00, 8'h00, 1, 8'hFF); tick();
    chk("post_reset_rd_ff", rd_data, 8'h00);
    drive(1, 8'h10, 8'hA5, 0, 8'h00); tick();
    drive(0, 8'h00, 8'h00, 1, 8'h10); tick();
    chk("basic_rd_10", rd_data, 8'hA5);
    for (int k = 0; k < 3; k++) begin
      drive(1, 8'h10, 8'h3C, 0, 8'h10); tick();
      chk("hold_a5", rd_data, 8'hA5);
    end
    drive(0, 8'h00, 8'h00, 1, 8'h10); tick();
    chk("rd_after_hold", rd_data, 8'h3C);
    drive(1, 8'h20, 8'h11, 0, 8'h00); tick();
    drive(1, 8'h20, 8'h22, 1, 8'h20); tick();
    chk("collision_old", rd_data, 8'h11);
    drive(0, 8'h00, 8'h00, 1, 8'h20); tick();
    chk("collision_new", rd_data, 8'h22);
    drive(1, 8'h40, 8'h99, 1, 8'h10); tick();
    chk("indep_rd_wr", rd_data, 8'h3C);
    for (int a = 0; a < 256; a++) begin
      drive(1, 8'(a), 8'(a) ^ 8'h5A, 0, 8'h00); tick();
    end
    for (int a = 0; a < 256; a++) begin
      drive(0, 8'h00, 8'h00, 1, 8'(a)); tick();
      chk("sweep", rd_data, 8'(a) ^ 8'h5A);
      if (a == 0) chk("sweep_00", rd_data, 8'h5A);
      if (a == 255) chk("sweep_ff", rd_data, 8'hA5);
    end
    drive(1, 8'h30, 8'h77, 1, 8'h05); tick();
    chk("pre_async", rd_data, 8'h5F);
    #2 rst = 1'b0;
    #1 chk("async_drop", rd_data, 8'h00);
    drive(1, 8'h31, 8'h88, 1, 8'h30); tick();
    chk("during_reset", rd_data, 8'h00);
    rst = 1'b1;
    drive(0, 8'h00, 8'h00, 1, 8'h10); tick();
    chk("cleared_10", rd_data, 8'h00);
    drive(0, 8'h00, 8'h00, 1, 8'h30); tick();
    chk("cleared_30", rd_data, 8'h00);
    drive(0, 8'h00, 8'h00, 1, 8'h31); tick();
    chk("discarded_31", rd_data, 8'h00);
    drive(0, 8'h00, 8'h00, 1, 8'hFF); tick();
    chk("cleared_ff", rd_data, 8'h00);
    drive(0, 8'h00, 8'h00, 0, 8'h00); tick(); tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/modport_ram.md
Name: modport_ram

Overview:
- Simple dual-port synchronous RAM: one write port and one independent read port, both on one clock.
- Write and read may target any addresses in the same cycle.
- Sits behind the ram_inf interface. The write driver/monitor use the wr_* signals; the read driver/monitor use the rd_* signals.
- Stimulus changes 1 time unit after posedge clk. Monitors sample 1 time unit after posedge clk.

Parameters:
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH locations (256 by default).
- DATA_WIDTH, 8, width of each memory word.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_enb  input  1  write enable.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- rd_enb  input  1  read enable.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  registered read data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset (rst=0, asynchronous, takes effect immediately, independent of clk):
  - rd_data goes to 0.
  - Every memory location is cleared to 0.
  - Writes and reads are ignored while rst=0.
- Reset deassertion: normal operation starts at the first rising clk edge with rst=1.
- Write, at posedge clk with rst=1 and wr_enb=1: mem[wr_addr] <= wr_data. No write when wr_enb=0.
- Read, at posedge clk with rst=1 and rd_enb=1: rd_data <= mem[rd_addr].
  - Latency is 1 clock: data is valid after the edge that sampled rd_enb and stays valid until the next read edge.
- rd_enb=0: rd_data holds its previous value. It is not cleared.
- Read-during-write to the same address in the same edge: read-first. rd_data returns the old contents; the new data is visible to a read on the following edge.
- Different addresses in the same edge: the read and write are fully independent.
- Address range: all addresses 0..2**ADDR_WIDTH-1 are valid. There is no wrap logic and no out-of-range case.
- Inputs are sampled only at the clock edge. X on wr_addr or rd_addr while the corresponding enable is 0 has no effect.
- Reset mid-operation: a write or read pending at an edge that coincides with rst=0 is discarded. Memory and rd_data are 0 afterwards.
- No handshake, stall or error signalling: every enabled access completes in one cycle.
- All arithmetic-free: data is stored and returned bit-exact at DATA_WIDTH.

Test Plan:
- Reset check: hold rst=0 for 2 cycles, then release. Read address 0x00 and 0xFF -> rd_data=0x00 for both, and rd_data=0 during reset.
- Basic write/read: write 0xA5 to 0x10, then read 0x10 on the next cycle -> rd_data=0xA5 one cycle after the read edge.
- Hold behaviour: after reading 0xA5, deassert rd_enb for 3 cycles while writing 0x3C to 0x10 -> rd_data stays 0xA5. A subsequent read of 0x10 returns 0x3C.
- Same-address collision: mem[0x20]=0x11, then in one cycle write 0x22 to 0x20 and read 0x20 -> rd_data=0x11. The next-cycle read returns 0x22.
- Boundary and full sweep: write data=addr^0x5A to all 256 addresses with back-to-back writes, then read back-to-back -> every read matches, including addr 0x00 (0x5A) and 0xFF (0xA5).
- Async reset mid-stream: assert rst=0 between clock edges during back-to-back traffic -> rd_data drops to 0 immediately. After release, reads of previously written addresses return 0.
